// File: rtl/row_result_assembler_if.sv
// Bundle of element-input and row-output signals for row_result_assembler.
// The row side is a valid/ready handshake: a row transfers on any rising edge where row_valid
// and row_ready are both high; row_valid never waits on row_ready, and the payload holds while
// row_valid is high and row_ready is low. The element side (in/validin) has no backpressure.
interface row_result_assembler_if #(
    parameter int DATA_W = 32,
    parameter int N      = 8
);
    logic [DATA_W-1:0]    in;
    logic                 validin;
    logic [N*DATA_W-1:0]  row_out;
    logic                 row_valid;
    logic                 row_ready;
    logic [$clog2(N)-1:0] row_index;
    logic                 block_last;
    logic                 overflow;
    logic                 busy;

    modport master (
        output in, validin, row_ready,
        input  row_out, row_valid, row_index, block_last, overflow, busy
    );

    modport slave (
        input  in, validin, row_ready,
        output row_out, row_valid, row_index, block_last, overflow, busy
    );
endinterface

// File: rtl/row_result_assembler.sv
// Packs a stream of DATA_W-bit dot-product results into N-element rows (element 0 in the MSBs)
// and queues completed rows, tagged with their position in the NxN block, in a small FIFO.
module row_result_assembler #(
    parameter int DATA_W = 32,
    parameter int N      = 8,
    parameter int DEPTH  = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    row_result_assembler_if.slave bus
);
    localparam int IDX_W = $clog2(N);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);

    logic [IDX_W-1:0]    col_cnt;
    logic [IDX_W-1:0]    row_cnt;
    logic [DATA_W-1:0]   slot_q [N];
    logic [N*DATA_W-1:0] row_next;

    logic [N*DATA_W-1:0] fifo_row  [DEPTH];
    logic [IDX_W-1:0]    fifo_idx  [DEPTH];
    logic                fifo_last [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                overflow_q;

    logic commit;
    logic pop;
    logic push;

    // The final element bypasses the slot registers so the whole row commits on its own edge.
    always_comb begin
        row_next = '0;
        for (int i = 0; i < N; i++) begin
            row_next[DATA_W*(N-i)-1 -: DATA_W] = (i == N - 1) ? bus.in : slot_q[i];
        end
    end

    assign commit = bus.validin && (col_cnt == LAST_COL);
    assign pop    = (count != '0) && bus.row_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts the row.
    assign push   = commit && ((count != FULL) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
            for (int i = 0; i < N; i++) slot_q[i] <= '0;
        end else if (bus.validin) begin
            slot_q[col_cnt] <= bus.in;
            col_cnt         <= (col_cnt == LAST_COL) ? '0 : col_cnt + 1'b1;
            if (commit) row_cnt <= (row_cnt == LAST_COL) ? '0 : row_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_row[i]  <= '0;
                fifo_idx[i]  <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_row[wr_ptr]  <= row_next;
                fifo_idx[wr_ptr]  <= row_cnt;
                fifo_last[wr_ptr] <= (row_cnt == LAST_COL);
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            // A dropped row still advanced row_cnt above, keeping block alignment.
            if (commit && !push) overflow_q <= 1'b1;
        end
    end

    assign bus.row_out    = fifo_row[rd_ptr];
    assign bus.row_index  = fifo_idx[rd_ptr];
    assign bus.block_last = fifo_last[rd_ptr];
    assign bus.row_valid  = (count != '0);
    assign bus.overflow   = overflow_q;
    assign bus.busy       = (col_cnt != '0) || (count != '0);
endmodule

// File: tb/tb_row_result_assembler.sv
// Bench for row_result_assembler: directed scenarios plus a randomized run against a
// queue-based reference model of row packing, tagging and the bounded row FIFO.
module tb_row_result_assembler;
    localparam int DATA_W = 32;
    localparam int N      = 8;
    localparam int DEPTH  = 2;
    localparam int RW     = N * DATA_W;
    localparam int EW     = RW + 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    row_result_assembler_if #(.DATA_W(DATA_W), .N(N)) bus ();

    row_result_assembler #(.DATA_W(DATA_W), .N(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: rows are {row, index, last}; FIFO capacity DEPTH.
    logic [EW-1:0] exp_q[$];
    logic [RW-1:0] cur_row;
    int            cur_cnt;
    int            row_num;
    bit            exp_ovf;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic model_reset();
        exp_q.delete();
        cur_row = '0;
        cur_cnt = 0;
        row_num = 0;
        exp_ovf = 0;
    endtask

    task automatic do_reset();
        bus.in        = '0;
        bus.validin   = 1'b0;
        bus.row_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // Drive one clock cycle and advance the model; returns #1 after the edge.
    task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit r);
        bus.validin   = v;
        bus.in        = d;
        bus.row_ready = r;
        @(posedge clk);
        if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
        if (v) begin
            cur_row[RW-1-DATA_W*cur_cnt -: DATA_W] = d;
            cur_cnt++;
            if (cur_cnt == N) begin
                cur_cnt = 0;
                if (exp_q.size() < DEPTH) exp_q.push_back({cur_row, 3'(row_num), row_num == N - 1});
                else exp_ovf = 1;
                row_num = (row_num + 1) % N;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        bus.in = '0; bus.validin = 1'b0; bus.row_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (bus.row_out !== '0)      begin n_fail++; $display("FAIL reset_row_out: got %h expected 0", bus.row_out); end
        n_tests++; if (bus.row_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_row_valid: got %b expected 0", bus.row_valid); end
        n_tests++; if (bus.row_index !== 3'd0)  begin n_fail++; $display("FAIL reset_row_index: got %0d expected 0", bus.row_index); end
        n_tests++; if (bus.block_last !== 1'b0) begin n_fail++; $display("FAIL reset_block_last: got %b expected 0", bus.block_last); end
        n_tests++; if (bus.overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        n_tests++; if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_row();
        logic [RW-1:0] ones = {N{32'h3f800000}};
        do_reset();
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, 32'h3f800000, 1'b1);
            if (i < N - 1) begin
                n_tests++; if (bus.row_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0 at element %0d", bus.row_valid, i); end
            end
        end
        n_tests++; if (bus.row_valid !== 1'b1)  begin n_fail++; $display("FAIL single_valid: got %b expected 1", bus.row_valid); end
        n_tests++; if (bus.row_out !== ones)    begin n_fail++; $display("FAIL single_row_out: got %h expected %h", bus.row_out, ones); end
        n_tests++; if (bus.row_index !== 3'd0)  begin n_fail++; $display("FAIL single_index: got %0d expected 0", bus.row_index); end
        n_tests++; if (bus.block_last !== 1'b0) begin n_fail++; $display("FAIL single_last: got %b expected 0", bus.block_last); end
        cycle(1'b0, '0, 1'b1);
        n_tests++; if (bus.row_valid !== 1'b0)  begin n_fail++; $display("FAIL single_after_valid: got %b expected 0", bus.row_valid); end
        n_tests++; if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL single_after_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_gaps();
        logic [RW-1:0] want = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
        logic [RW-1:0] seen = '0;
        int pulses = 0;
        do_reset();
        for (int k = 1; k <= N; k++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                cycle(1'b0, $urandom, 1'b1);
                if (bus.row_valid === 1'b1) begin pulses++; seen = bus.row_out; end
            end
            cycle(1'b1, 32'(k), 1'b1);
            if (bus.row_valid === 1'b1) begin pulses++; seen = bus.row_out; end
        end
        for (int g = 0; g < 4; g++) begin
            cycle(1'b0, $urandom, 1'b1);
            if (bus.row_valid === 1'b1) begin pulses++; seen = bus.row_out; end
        end
        n_tests++; if (pulses != 1)  begin n_fail++; $display("FAIL gaps_pulses: got %0d expected 1", pulses); end
        n_tests++; if (seen !== want) begin n_fail++; $display("FAIL gaps_row_out: got %h expected %h", seen, want); end
    endtask

    task automatic test_overflow();
        logic [RW-1:0] rows [4];
        logic [DATA_W-1:0] e;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < N; j++) begin
                e = $urandom;
                rows[r][RW-1-DATA_W*j -: DATA_W] = e;
                cycle(1'b1, e, 1'b0);
            end
        end
        n_tests++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
        for (int h = 0; h < 3; h++) begin
            cycle(1'b0, '0, 1'b0);
            n_tests++; if (bus.row_out !== rows[0]) begin n_fail++; $display("FAIL ovf_hold_a: got %h expected %h", bus.row_out, rows[0]); end
            n_tests++; if (bus.row_index !== 3'd0)  begin n_fail++; $display("FAIL ovf_hold_idx: got %0d expected 0", bus.row_index); end
        end
        cycle(1'b0, '0, 1'b1);
        n_tests++; if (bus.row_valid !== 1'b1)  begin n_fail++; $display("FAIL ovf_b_valid: got %b expected 1", bus.row_valid); end
        n_tests++; if (bus.row_out !== rows[1]) begin n_fail++; $display("FAIL ovf_b_row: got %h expected %h", bus.row_out, rows[1]); end
        n_tests++; if (bus.row_index !== 3'd1)  begin n_fail++; $display("FAIL ovf_b_idx: got %0d expected 1", bus.row_index); end
        cycle(1'b0, '0, 1'b1);
        n_tests++; if (bus.row_valid !== 1'b0)  begin n_fail++; $display("FAIL ovf_drained: got %b expected 0", bus.row_valid); end
        for (int j = 0; j < N; j++) cycle(1'b1, $urandom, 1'b1);
        n_tests++; if (bus.row_index !== 3'd3)  begin n_fail++; $display("FAIL ovf_next_idx: got %0d expected 3", bus.row_index); end
        n_tests++; if (bus.overflow !== 1'b1)   begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
    endtask

    task automatic test_block();
        logic [EW-1:0] h;
        int rows_seen = 0;
        do_reset();
        for (int i = 0; i < 9 * N; i++) begin
            cycle(1'b1, $urandom, 1'b1);
            if (bus.row_valid === 1'b1) begin
                n_tests++; if (bus.row_index !== 3'(rows_seen % N)) begin n_fail++; $display("FAIL block_idx: got %0d expected %0d", bus.row_index, rows_seen % N); end
                n_tests++; if (bus.block_last !== ((rows_seen % N) == N - 1)) begin n_fail++; $display("FAIL block_last: got %b at row %0d", bus.block_last, rows_seen); end
                if (exp_q.size() != 0) begin
                    h = exp_q[0];
                    n_tests++; if (bus.row_out !== h[EW-1:4]) begin n_fail++; $display("FAIL block_row: got %h expected %h", bus.row_out, h[EW-1:4]); end
                end
                rows_seen++;
            end
        end
        n_tests++; if (rows_seen != 9) begin n_fail++; $display("FAIL block_count: got %0d expected 9", rows_seen); end
    endtask

    task automatic test_full_push_pop();
        logic [RW-1:0] rows [3];
        logic [DATA_W-1:0] e;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < N; j++) begin
                e = $urandom;
                rows[r][RW-1-DATA_W*j -: DATA_W] = e;
                cycle(1'b1, e, (r == 2 && j == N - 1));
            end
        end
        n_tests++; if (bus.overflow !== 1'b0)   begin n_fail++; $display("FAIL fpp_overflow: got %b expected 0", bus.overflow); end
        n_tests++; if (bus.row_out !== rows[1]) begin n_fail++; $display("FAIL fpp_head1: got %h expected %h", bus.row_out, rows[1]); end
        n_tests++; if (bus.row_index !== 3'd1)  begin n_fail++; $display("FAIL fpp_idx1: got %0d expected 1", bus.row_index); end
        cycle(1'b0, '0, 1'b1);
        n_tests++; if (bus.row_valid !== 1'b1)  begin n_fail++; $display("FAIL fpp_valid2: got %b expected 1", bus.row_valid); end
        n_tests++; if (bus.row_out !== rows[2]) begin n_fail++; $display("FAIL fpp_head2: got %h expected %h", bus.row_out, rows[2]); end
        n_tests++; if (bus.row_index !== 3'd2)  begin n_fail++; $display("FAIL fpp_idx2: got %0d expected 2", bus.row_index); end
        cycle(1'b0, '0, 1'b1);
        n_tests++; if (bus.row_valid !== 1'b0)  begin n_fail++; $display("FAIL fpp_empty: got %b expected 0", bus.row_valid); end
    endtask

    task automatic test_reset_mid_row();
        logic [RW-1:0] want = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b1);
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", bus.busy); end
        bus.validin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (bus.row_out !== '0)      begin n_fail++; $display("FAIL mid_row_out: got %h expected 0", bus.row_out); end
        n_tests++; if (bus.row_valid !== 1'b0)  begin n_fail++; $display("FAIL mid_row_valid: got %b expected 0", bus.row_valid); end
        n_tests++; if (bus.row_index !== 3'd0)  begin n_fail++; $display("FAIL mid_row_index: got %0d expected 0", bus.row_index); end
        n_tests++; if (bus.block_last !== 1'b0) begin n_fail++; $display("FAIL mid_block_last: got %b expected 0", bus.block_last); end
        n_tests++; if (bus.overflow !== 1'b0)   begin n_fail++; $display("FAIL mid_overflow: got %b expected 0", bus.overflow); end
        n_tests++; if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL mid_busy_clear: got %b expected 0", bus.busy); end
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        for (int k = 1; k <= N; k++) cycle(1'b1, 32'(k), 1'b0);
        n_tests++; if (bus.row_valid !== 1'b1) begin n_fail++; $display("FAIL mid_clean_valid: got %b expected 1", bus.row_valid); end
        n_tests++; if (bus.row_out !== want)   begin n_fail++; $display("FAIL mid_clean_row: got %h expected %h", bus.row_out, want); end
        n_tests++; if (bus.row_index !== 3'd0) begin n_fail++; $display("FAIL mid_clean_idx: got %0d expected 0", bus.row_index); end
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        logic [EW-1:0] h;
        bit v, r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = (i % 150 < 100) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
            cycle(v, $urandom, r);
            n_tests++; if (bus.row_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid: got %b expected %b cycle %0d", bus.row_valid, exp_q.size() != 0, i); end
            n_tests++; if (bus.overflow !== exp_ovf) begin n_fail++; $display("FAIL rnd_overflow: got %b expected %b cycle %0d", bus.overflow, exp_ovf, i); end
            n_tests++; if (bus.busy !== (cur_cnt != 0 || exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_busy: got %b cycle %0d", bus.busy, i); end
            if (exp_q.size() != 0) begin
                h = exp_q[0];
                n_tests++; if (bus.row_out !== h[EW-1:4])  begin n_fail++; $display("FAIL rnd_row: got %h expected %h cycle %0d", bus.row_out, h[EW-1:4], i); end
                n_tests++; if (bus.row_index !== h[3:1])   begin n_fail++; $display("FAIL rnd_idx: got %0d expected %0d cycle %0d", bus.row_index, h[3:1], i); end
                n_tests++; if (bus.block_last !== h[0])    begin n_fail++; $display("FAIL rnd_last: got %b expected %b cycle %0d", bus.block_last, h[0], i); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_gaps();
        test_overflow();
        test_block();
        test_full_push_pop();
        test_reset_mid_row();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
